// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase sequencer.
// Also holds the first-unmasked-phase helper used on start and on wrap.
package phase_seq_pkg;

    localparam int unsigned NUM_PHASES = 8;
    localparam int unsigned PHASE_W    = 3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } seq_state_e;

    // Lowest index whose mask bit is clear; 0 when everything is masked.
    function automatic logic [PHASE_W-1:0] first_phase(input logic [NUM_PHASES-1:0] mask);
        logic [PHASE_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                idx = PHASE_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/phase_next_sel.sv
// Combinational finder for the next unmasked phase above the current index.
// With an all-zero mask this is a plain increment with last asserted at index 7.
module phase_next_sel
    import phase_seq_pkg::*;
(
    input  logic [PHASE_W-1:0]    idx_i,
    input  logic [NUM_PHASES-1:0] mask_i,
    output logic [PHASE_W-1:0]    next_idx_o,
    output logic                  last_o
);

    // Descending scan so the lowest qualifying index is the final assignment.
    always_comb begin
        next_idx_o = idx_i;
        last_o     = 1'b1;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if ((i > int'(idx_i)) && !mask_i[i]) begin
                next_idx_o = PHASE_W'(i);
                last_o     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Programmable phase sequencer: steps a 3-bit phase index, holding each for dwell+1 cycles.
// Optional phase skipping is enabled by defining PHASE_SEQ_SKIP_EN.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef PHASE_SEQ_SKIP_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic [2:0]         state,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    seq_state_e                fsm_q, fsm_d;
    logic [PHASE_W-1:0]        phase_q, phase_d;
    logic [DWELL_W-1:0]        cnt_q, cnt_d;
    logic [DWELL_W-1:0]        dwell_q, dwell_d;
    logic                      mode_q, mode_d;
    logic [NUM_PHASES-1:0]     mask_q, mask_d;
    logic                      done_q, done_d;
    logic                      wrap_q, wrap_d;
    logic [NUM_PHASES-1:0]     mask_in;
    logic [PHASE_W-1:0]        next_idx;
    logic                      next_last;

`ifdef PHASE_SEQ_SKIP_EN
    assign mask_in = skip_mask;
`else
    assign mask_in = '0;
`endif

    phase_next_sel u_next_sel (
        .idx_i      (phase_q),
        .mask_i     (mask_q),
        .next_idx_o (next_idx),
        .last_o     (next_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            phase_q <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (start && !stop && !(&mask_in)) begin
                    fsm_d   = StRun;
                    phase_d = first_phase(mask_in);
                    cnt_d   = '0;
                    dwell_d = dwell;
                    mode_d  = mode;
                    mask_d  = mask_in;
                end
            end
            StRun, StHold: begin
                if (stop) begin
                    fsm_d   = StIdle;
                    phase_d = '0;
                    cnt_d   = '0;
                end else if (hold) begin
                    fsm_d = StHold;
                end else begin
                    // The cycle in which hold drops already counts, so a held phase
                    // lasts dwell+1 plus exactly the number of cycles hold was high.
                    fsm_d = StRun;
                    if (cnt_q == dwell_q) begin
                        cnt_d = '0;
                        if (!next_last) begin
                            phase_d = next_idx;
                        end else if (mode_q) begin
                            phase_d = first_phase(mask_q);
                            wrap_d  = 1'b1;
                        end else begin
                            fsm_d   = StIdle;
                            phase_d = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
            end
            default: begin
                fsm_d   = StIdle;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        state = phase_q;
        busy  = (fsm_q != StIdle);
        done  = done_q;
        wrap  = wrap_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table plus directed multi-cycle sequences.
// Skip-mask cases are compiled only when PHASE_SEQ_SKIP_EN is defined.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] dwell = 8'd0;
`ifdef PHASE_SEQ_SKIP_EN
    logic [7:0] skip_mask = 8'd0;
`endif
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       hold;
        logic       mode;
        logic [7:0] dwell;
        logic [2:0] e_state;
        logic       e_busy;
        logic       e_done;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[$];

    phase_sequencer #(
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .dwell     (dwell),
`ifdef PHASE_SEQ_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .state     (state),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic sp, input logic hd, input logic md,
                                input logic [7:0] dw, input logic [2:0] es, input logic eb,
                                input logic ed, input logic ew);
        vec_t v;
        v.start = st; v.stop = sp; v.hold = hd; v.mode = md; v.dwell = dw;
        v.e_state = es; v.e_busy = eb; v.e_done = ed; v.e_wrap = ew;
        return v;
    endfunction

    initial begin
        int len;
        int done_cnt;
        int exp_seq[8];

        // Continuous dwell=0 run, ignored start, mid-run dwell/mode changes, stop+hold abort.
        vecs.push_back(mk(0, 0, 0, 0, 8'd0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 8'd0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'd0, 3'd0, 1, 0, 0));
        for (int p = 1; p < 8; p++) begin
            vecs.push_back(mk(0, 0, 0, 0, 8'd7, 3'(p), 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 8'd7, 3'd0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'd5, 3'd1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 3'd2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'd5, 3'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'd5, 3'd0, 0, 0, 0));

        #3;
        check("reset.state", int'(state), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.done", int'(done), 0);
        check("reset.wrap", int'(wrap), 0);
        #9 rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            start = vecs[i].start; stop = vecs[i].stop; hold = vecs[i].hold;
            mode = vecs[i].mode; dwell = vecs[i].dwell;
            step();
            check($sformatf("vec%0d.state", i), int'(state), int'(vecs[i].e_state));
            check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].e_done));
            check($sformatf("vec%0d.wrap", i), int'(wrap), int'(vecs[i].e_wrap));
        end
        start = 0; stop = 0; hold = 0;

        // Single pass, dwell=2: each phase 3 cycles, 24 busy cycles, then done with state 0.
        start = 1; mode = 0; dwell = 8'd2;
        step();
        start = 0;
        done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("single.c%0d.state", i), int'(state), i / 3);
            check($sformatf("single.c%0d.busy", i), int'(busy), 1);
            if (done) done_cnt++;
            step();
        end
        check("single.end.busy", int'(busy), 0);
        check("single.end.state", int'(state), 0);
        check("single.end.done", int'(done), 1);
        step();
        check("single.done_pulse_len", int'(done), 0);
        check("single.early_done", done_cnt, 0);

        // Hold for 5 cycles in phase 2 after one count: phase 2 lasts 9 cycles.
        start = 1; mode = 0; dwell = 8'd3;
        step();
        start = 0;
        repeat (8) step();
        check("hold.at_phase2", int'(state), 2);
        len = 1;
        step();
        if (state == 3'd2) len++;
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (state == 3'd2) len++;
        end
        check("hold.busy_in_hold", int'(busy), 1);
        hold = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (state != 3'd2) break;
            len++;
        end
        check("hold.phase2_len", len, 9);
        check("hold.next_phase", int'(state), 3);

        // Hold on the expiry cycle of phase 3 delays the advance.
        repeat (3) step();
        hold = 1;
        repeat (2) step();
        check("hold_exp.frozen", int'(state), 3);
        hold = 0;
        step();
        check("hold_exp.advance", int'(state), 4);
        stop = 1;
        step();
        stop = 0;
        check("stop.state", int'(state), 0);
        check("stop.busy", int'(busy), 0);
        check("stop.done", int'(done), 0);

        // Asynchronous reset mid-run, then no stray done afterwards.
        start = 1; mode = 0; dwell = 8'd0;
        step();
        start = 0;
        repeat (5) step();
        check("rst.pre_state", int'(state), 5);
        rst_n = 0;
        #1;
        check("rst.async_state", int'(state), 0);
        check("rst.async_busy", int'(busy), 0);
        step();
        rst_n = 1;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) done_cnt++;
        end
        check("rst.idle_after", done_cnt, 0);

`ifdef PHASE_SEQ_SKIP_EN
        // Mask 1010_0101, dwell=1: phases 1,3,4,6 two cycles each, then done.
        exp_seq = '{1, 1, 3, 3, 4, 4, 6, 6};
        skip_mask = 8'b1010_0101; start = 1; mode = 0; dwell = 8'd1;
        step();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("skip.c%0d.state", i), int'(state), exp_seq[i]);
            check($sformatf("skip.c%0d.busy", i), int'(busy), 1);
            step();
        end
        check("skip.done", int'(done), 1);
        check("skip.idle", int'(busy), 0);
        skip_mask = 8'hFF; start = 1;
        step();
        start = 0;
        check("skip_all.busy", int'(busy), 0);
        step();
        check("skip_all.done", int'(done), 0);
        skip_mask = 8'h00;
`else
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0};
        check("nomask.idle", int'(busy), exp_seq[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Programmable 3-bit phase sequencer.
- Steps a phase index 0..7, holding each phase for a programmable dwell time.
- Drives the 3-bit state input of the downstream 3-to-8 one-hot decoder, which turns the index into per-phase enables on the bus.
- Supports single-pass and continuous operation, with pause and abort control.

## Interface
- DWELL_W, 8: width of dwell count; each phase lasts dwell+1 cycles.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sequence; honoured only in IDLE.
- stop  in  1  abort; returns to IDLE from RUN or HOLD.
- hold  in  1  level; freezes phase and dwell counter while high.
- mode  in  1  0 = single pass, 1 = continuous; sampled at start.
- dwell  in  DWELL_W  cycles-minus-one per phase; sampled at start.
- state  out  3  current phase index, fed to the decoder.
- busy  out  1  high in RUN and HOLD.
- done  out  1  one-cycle pulse on completion of a single pass.
- wrap  out  1  one-cycle pulse when continuous mode returns to the first phase.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - state=0, busy=0.
  - On start: latch mode and dwell, load the first phase, clear the dwell counter, go to RUN.
- RUN:
  - The dwell counter increments each cycle.
  - When counter == latched dwell, the counter clears and the phase advances to the next index.
  - After phase 7 in single mode: go to IDLE, set state=0, pulse done.
  - After phase 7 in continuous mode: load the first phase again and pulse wrap.
- HOLD:
  - Entered from RUN when hold=1.
  - Counter and phase are frozen.
  - Returns to RUN when hold=0, resuming at the frozen count.
- Priority when inputs coincide: stop > hold > dwell expiry.
  - stop in RUN or HOLD: go to IDLE, state=0, no done or wrap.
- start while busy is ignored; start and stop together in IDLE also ignore start.
- Counter arithmetic is unsigned DWELL_W bits. dwell=0 advances one phase per cycle. The counter never wraps, because it is cleared at the latched dwell value.
- Changes on dwell or mode inputs during a sequence have no effect until the next start.

## Timing
- Reset values: state=0, busy=0, done=0, wrap=0, FSM=IDLE, counter=0, latched dwell and mode = 0.
- All outputs are registered; none is combinational from inputs.
- start sampled in cycle N: busy=1 and state=first phase from cycle N+1.
- Each phase is visible for exactly dwell+1 cycles, excluding HOLD cycles.
- Single-pass length: 8×(dwell+1) cycles of busy.
- done is asserted in the first IDLE cycle, together with busy=0 and state=0.
- wrap is asserted in the first cycle of the repeated first phase.
- hold sampled high in cycle N: state and counter are unchanged from N+1 onward.
- Hold takes priority over expiry in the same cycle: a phase expiring in cycle N with hold=1 does not advance.
- stop sampled in cycle N: IDLE outputs from N+1.
- Reset asserted mid-sequence forces reset values asynchronously. After deassertion the block waits in IDLE for a new start.

## Configuration
- PHASE_SEQ_SKIP_EN defined:
  - Adds input skip_mask[7:0], sampled at start. Bit i=1 skips phase i.
  - "First phase" means the lowest unmasked index; advance goes to the next unmasked index; the pass ends after the highest unmasked index.
  - start with skip_mask=8'hFF is ignored: the block stays in IDLE with no pulses.
- PHASE_SEQ_SKIP_EN undefined:
  - No skip_mask port.
  - All eight phases are always visited in order 0..7.

## Structure
- Shared package phase_seq_pkg holds:
  - the FSM state enum (IDLE/RUN/HOLD);
  - constant NUM_PHASES=8;
  - constant PHASE_W=3.
- One sub-module, phase_next_sel, is natural when skip is enabled.
  - Combinational next-unmasked-index finder: inputs current index and mask; outputs next index and a last flag.
  - Without skip it reduces to increment, with last when index==7.

## Test plan
- Reset then idle: rst_n low mid-run with state=5 → state=0 and busy=0 immediately; no done after release.
- Single pass: dwell=2, mode=0, start → each of 0..7 held 3 cycles, busy high 24 cycles, done pulse once with state=0.
- Continuous: dwell=0, mode=1 → state 0..7 repeats every 8 cycles, wrap pulse on each return to 0; stop → IDLE next cycle, no done.
- Hold: dwell=3, raise hold for 5 cycles in phase 2 after 1 count → phase 2 lasts 9 cycles total; hold coinciding with expiry delays the advance.
- Priority and ignore cases:
  - stop and hold together → IDLE.
  - start while busy → no restart.
  - dwell changed mid-run → no effect.
- Skip (PHASE_SEQ_SKIP_EN):
  - mask 8'b1010_0101, dwell=1 → sequence 1,3,4,6, two cycles each, then done.
  - mask 8'hFF → start ignored.
